// File: rtl/key_sched_iter_pkg.sv
// Shared AES definitions: round count, S-box table, GF(2^8) doubling and rcon seed.
// Also used by the byte-substitution and column-mixing stages.
package key_sched_iter_pkg;

    localparam int AES_NR = 10;
    localparam logic [7:0] RCON_INIT = 8'h01;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } ks_state_e;

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

endpackage

// File: rtl/key_sched_iter_if.sv
// Request/round-key handshake bundle between the key schedule and its user.
interface key_sched_iter_if;
    logic         start;
    logic [127:0] key_in;
    logic         rk_valid;
    logic         rk_ready;
    logic [127:0] round_key;
    logic [3:0]   round_idx;
    logic         busy;
    logic         done;

    modport master (
        output start, key_in, rk_ready,
        input  rk_valid, round_key, round_idx, busy, done
    );

    modport slave (
        input  start, key_in, rk_ready,
        output rk_valid, round_key, round_idx, busy, done
    );
endinterface

// File: rtl/key_sched_iter_aes_sbox_byte.sv
// Combinational AES S-box lookup for a single byte.
module aes_sbox_byte
    import key_sched_iter_pkg::*;
(
    input  logic [7:0] in_i,
    output logic [7:0] out_o
);
    assign out_o = SBOX[in_i];
endmodule

// File: rtl/key_sched_iter.sv
// Iterative AES-128 key expansion: one 128-bit working key updated in place,
// emitting round keys 0..NR through a valid/ready handshake.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_IDLE | no schedule active; waits for start
//   ST_RUN  | round_key/round_idx presented; advances on each acceptance
module key_sched_iter
    import key_sched_iter_pkg::*;
#(
    parameter int NR = AES_NR
) (
    input  logic             clk,
    input  logic             rst,
    key_sched_iter_if.slave  ks
);
    localparam logic [3:0] LAST_IDX = 4'(NR);

    ks_state_e    state_q, state_d;
    logic [127:0] key_q, key_d;
    logic [3:0]   idx_q, idx_d;
    logic [7:0]   rcon_q, rcon_d;
    logic         valid_q, valid_d;
    logic         busy_q, busy_d;
    logic         done_q, done_d;

    logic [31:0]  w0, w1, w2, w3;
    logic [31:0]  rot_w3, sub_w3, t_word;
    logic [31:0]  n0, n1, n2, n3;

    assign w0 = key_q[127:96];
    assign w1 = key_q[95:64];
    assign w2 = key_q[63:32];
    assign w3 = key_q[31:0];

    assign rot_w3 = {w3[23:0], w3[31:24]};

    for (genvar b = 0; b < 4; b++) begin : g_subword
        aes_sbox_byte u_sbox (
            .in_i  (rot_w3[8*b +: 8]),
            .out_o (sub_w3[8*b +: 8])
        );
    end

    assign t_word = sub_w3 ^ {rcon_q, 24'h000000};
    assign n0     = w0 ^ t_word;
    assign n1     = w1 ^ n0;
    assign n2     = w2 ^ n1;
    assign n3     = w3 ^ n2;

    always_comb begin
        state_d = state_q;
        key_d   = key_q;
        idx_d   = idx_q;
        rcon_d  = rcon_q;
        valid_d = valid_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (ks.start) begin
                    key_d   = ks.key_in;
                    idx_d   = 4'd0;
                    rcon_d  = RCON_INIT;
                    valid_d = 1'b1;
                    busy_d  = 1'b1;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (valid_q && ks.rk_ready) begin
                    if (idx_q == LAST_IDX) begin
                        valid_d = 1'b0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        key_d  = {n0, n1, n2, n3};
                        idx_d  = idx_q + 4'd1;
                        rcon_d = xtime(rcon_q);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            key_q   <= '0;
            idx_q   <= '0;
            rcon_q  <= RCON_INIT;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            idx_q   <= idx_d;
            rcon_q  <= rcon_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign ks.rk_valid  = valid_q;
    assign ks.round_key = key_q;
    assign ks.round_idx = idx_q;
    assign ks.busy      = busy_q;
    assign ks.done      = done_q;

endmodule

// File: doc/key_sched_iter.md
Name: key_sched_iter

Overview:
- Iterative AES-128 key schedule that produces round keys 0..10, one per accepted handshake.
- Sits beside the round datapath and feeds the add-round-key stage directly downstream of the column-mixing stage.
- Holds one 128-bit working key and derives each next round key in place.
- Removes the need for a full 1408-bit precomputed key store.

Parameters:
- NR, 10: number of rounds. The last round key emitted has index NR. Only 10 (AES-128) is supported.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  reset, synchronous and active-high.
- start  in  1  one-cycle request to load key_in and begin a new schedule. Honoured only when busy=0.
- key_in  in  128  cipher key. Word w0 = key_in[127:96], w3 = key_in[31:0].
- rk_valid  out  1  round_key and round_idx are valid.
- rk_ready  in  1  consumer accepts the current round key when rk_valid && rk_ready.
- round_key  out  128  current round key, same word ordering as key_in.
- round_idx  out  4  index of round_key, 0..NR.
- busy  out  1  schedule in progress.
- done  out  1  one-cycle pulse, registered, in the cycle after round key NR is accepted.

Behaviour:
- Reset (rst=1 at a clock edge), all outputs registered:
  - rk_valid=0, busy=0, done=0, round_idx=0, round_key=0, internal rcon=8'h01, state=IDLE.
  - Reset has priority over every other input.
- States: IDLE, RUN.
- IDLE:
  - start=1 at edge t: round_key<=key_in, round_idx<=0, rcon<=8'h01, rk_valid<=1, busy<=1, go RUN.
  - rk_valid is high from cycle t+1, giving 1-cycle latency.
- RUN, no acceptance (rk_valid && !rk_ready): round_key, round_idx and rk_valid hold stable.
- RUN, acceptance with round_idx<NR, at the same edge:
  - round_key <= next(round_key, rcon); round_idx += 1; rcon <= xtime(rcon).
  - rk_valid stays 1, so a back-to-back key is available every cycle while rk_ready=1.
- RUN, acceptance with round_idx==NR:
  - rk_valid<=0, busy<=0, done<=1, go IDLE.
  - done self-clears after one cycle.
- next() function, with ^ as bitwise XOR:
  - t = SubWord(RotWord(w3)) ^ {rcon, 24'h0}
  - w0' = w0 ^ t; w1' = w1 ^ w0'; w2' = w2 ^ w1'; w3' = w3 ^ w2'.
  - RotWord({a,b,c,d}) = {b,c,d,a}.
  - SubWord applies the AES S-box to each byte.
- rcon sequence: 01,02,04,08,10,20,40,80,1b,36.
  - xtime(x) = x[7] ? (x<<1)^8'h1b : x<<1, truncated to 8 bits.
- start while busy=1 is ignored, including in the same cycle as the final acceptance. No queueing.
- key_in is sampled only on an honoured start; later changes have no effect.
- rst asserted mid-schedule: return to IDLE next edge with rk_valid=0. No done pulse.
- done and rk_valid are never high in the same cycle.
- Combinational path: rk_ready to the state registers only. No combinational path from any input to any output.

Decomposition:
- Shared AES package holds:
  - constant AES_NR=10
  - the 256-entry S-box table
  - the xtime function (the same GF(2^8) multiply-by-2 used by the column-mixing stage)
  - the rcon initial value 8'h01
- One natural sub-module: aes_sbox_byte (8-bit in, 8-bit out, combinational), instantiated 4 times for SubWord.
  - The same sub-module is reused by the byte-substitution stage.

Test Plan:
- FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c, rk_ready=1 constant, start pulse:
  - idx0 = 2b7e151628aed2a6abf7158809cf4f3c
  - idx1 = a0fafe1788542cb123a339392a6c7605
  - idx10 = d014f9a8c9ee2589e13f0cc8b6630ca6
  - 11 consecutive valid cycles, then done=1 for exactly one cycle; busy=0 afterwards.
- Backpressure: same key, rk_ready toggled pseudo-randomly.
  - round_key/round_idx never change while rk_valid && !rk_ready.
  - Accepted sequence is identical to the previous test.
- All-zero key 000...0:
  - idx1 = 62636363626363636263636362636363
  - idx10 = b4ef5bcb3e92e21123e951cf6f8f188e
- start pulsed with a different key during RUN (including at the idx10 acceptance cycle):
  - ignored; the original schedule completes unchanged, then IDLE.
- rst asserted while round_idx=5 and rk_valid=1:
  - next cycle rk_valid=0, busy=0, round_idx=0, done stays 0.
  - A following start produces a correct idx0..idx10 sequence.
- Reset values:
  - after rst, all outputs are 0 until start.
  - start issued in the same cycle as rst=1 is ignored.
